// File: rtl/pipe_gen.sv
// Flappy Bird obstacle generator: scrolls a 16x16 green playfield one column per tick,
// feeding in blank columns and pipe walls with an LFSR-chosen gap.
module pipe_gen #(
    parameter int TICK_DIV = 12_500_000,
    parameter int SPACING  = 4,
    parameter int PIPE_W   = 2,
    parameter int GAP_H    = 4,
    parameter int BIRD_COL = 2
) (
    input  logic         Clock,
    input  logic         RST,
    input  logic         enable,
    input  logic         stop,
    output logic [255:0] green_array,
    output logic [15:0]  greenpix,
    output logic         tick
);

    localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_MAX = (SPACING > PIPE_W) ? SPACING : PIPE_W;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] SPACE_LAST = CNT_W'(SPACING - 1);
    localparam logic [CNT_W-1:0] WALL_LAST  = CNT_W'(PIPE_W - 1);
    localparam logic [15:0]      GAP_ONES   = 16'((1 << GAP_H) - 1);

    typedef enum logic {SPACE, WALL} state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]   col_cnt_q, col_cnt_d;
    logic [3:0]         gap_top_q, gap_top_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [255:0]       green_q, green_d;
    logic               tick_q, tick_d;
    logic               running;
    logic               scroll;
    logic [15:0]        new_col;

    always_comb begin
        running   = enable & ~stop;
        scroll    = running && (div_cnt_q == DIV_LAST);
        lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        div_cnt_d = div_cnt_q;
        if (running) begin
            div_cnt_d = scroll ? '0 : div_cnt_q + DIV_W'(1);
        end
        new_col   = (state_q == WALL) ? ~(GAP_ONES << gap_top_q) : 16'h0000;
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        gap_top_d = gap_top_q;
        green_d   = green_q;
        tick_d    = scroll;
        if (scroll) begin
            // Each row shifts left by one; the new column enters at column 15.
            for (int r = 0; r < 16; r++) begin
                green_d[r*16 +: 16] = {new_col[r], green_q[r*16+1 +: 15]};
            end
            case (state_q)
                SPACE: begin
                    if (col_cnt_q == SPACE_LAST) begin
                        state_d   = WALL;
                        col_cnt_d = '0;
                        gap_top_d = {1'b0, lfsr_q[2:0]} + 4'd2;
                    end else begin
                        col_cnt_d = col_cnt_q + CNT_W'(1);
                    end
                end
                WALL: begin
                    if (col_cnt_q == WALL_LAST) begin
                        state_d   = SPACE;
                        col_cnt_d = '0;
                    end else begin
                        col_cnt_d = col_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d   = SPACE;
                    col_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge RST) begin
        if (!RST) begin
            state_q   <= SPACE;
            div_cnt_q <= '0;
            col_cnt_q <= '0;
            gap_top_q <= 4'd2;
            lfsr_q    <= 8'hA5;
            green_q   <= '0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            col_cnt_q <= col_cnt_d;
            gap_top_q <= gap_top_d;
            lfsr_q    <= lfsr_d;
            green_q   <= green_d;
            tick_q    <= tick_d;
        end
    end

    always_comb begin
        greenpix = '0;
        for (int r = 0; r < 16; r++) begin
            greenpix[r] = green_q[r*16 + BIRD_COL];
        end
    end

    assign green_array = green_q;
    assign tick        = tick_q;

endmodule

// File: tb/tb_pipe_gen.sv
// Randomized bench for pipe_gen against a column-list model of the scrolling playfield.
module tb_pipe_gen;

    localparam int TICK_DIV = 2;
    localparam int SPACING  = 4;
    localparam int PIPE_W   = 2;
    localparam int GAP_H    = 4;
    localparam int BIRD_COL = 2;
    localparam int PERIOD   = SPACING + PIPE_W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         stop = 1'b0;
    logic [255:0] green_array;
    logic [15:0]  greenpix;
    logic         tick;

    int total = 0;
    int bad   = 0;

    pipe_gen #(
        .TICK_DIV(TICK_DIV), .SPACING(SPACING), .PIPE_W(PIPE_W),
        .GAP_H(GAP_H), .BIRD_COL(BIRD_COL)
    ) dut (
        .Clock(clk), .RST(rst_n), .enable(enable), .stop(stop),
        .green_array(green_array), .greenpix(greenpix), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: playfield as a list of columns, scroll number decides column kind.
    logic [15:0] m_col [16];
    logic [7:0]  m_lfsr;
    int          m_run_cnt;
    int          m_scrolls;
    int          m_gap;
    logic        m_tick;
    logic [15:0] m_new;
    int          m_pos;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 16; c++) m_col[c] = 16'h0;
            m_lfsr = 8'hA5; m_run_cnt = 0; m_scrolls = 0; m_gap = 2; m_tick = 1'b0;
        end else begin
            m_tick = 1'b0;
            if (enable && !stop) begin
                m_run_cnt++;
                if (m_run_cnt == TICK_DIV) begin
                    m_run_cnt = 0;
                    m_pos = m_scrolls % PERIOD;
                    if (m_pos < SPACING) m_new = 16'h0;
                    else m_new = ~(16'((1 << GAP_H) - 1) << m_gap);
                    if (m_pos == SPACING - 1) m_gap = int'(m_lfsr[2:0]) + 2;
                    for (int c = 0; c < 15; c++) m_col[c] = m_col[c+1];
                    m_col[15] = m_new;
                    m_scrolls++;
                    m_tick = 1'b1;
                end
            end
            m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        end
    end

    function automatic logic [255:0] model_array();
        logic [255:0] v;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                v[r*16+c] = m_col[c][r];
        return v;
    endfunction

    function automatic logic [15:0] dut_col(input logic [255:0] ga, input int c);
        logic [15:0] v;
        for (int r = 0; r < 16; r++) v[r] = ga[r*16+c];
        return v;
    endfunction

    // Monitor: full-array compare every cycle plus per-scroll column properties.
    int          tick_cnt = 0;
    int          wall_cols = 0;
    int          first_wall_tick = -1;
    bit          bird_done = 1'b0;
    logic [15:0] first_wall;
    logic [15:0] prev_wall;
    logic [15:0] c15;
    int          gt;
    int          p;
    bit          seen [16];

    always @(negedge clk) begin
        if (!rst_n) begin
            tick_cnt = 0;
        end else begin
            chk("array", green_array, model_array());
            chk("greenpix", {240'h0, greenpix}, {240'h0, m_col[BIRD_COL]});
            chk("tick", {255'h0, tick}, {255'h0, m_tick});
            if (tick) begin
                tick_cnt++;
                c15 = dut_col(green_array, 15);
                p = (tick_cnt - 1) % PERIOD;
                if (p < SPACING) begin
                    chk("blank_col", {240'h0, c15}, 256'h0);
                end else begin
                    chk("wall_ones", 256'($countones(c15)), 256'(16 - GAP_H));
                    gt = 16;
                    for (int r = 15; r >= 0; r--) if (!c15[r]) gt = r;
                    chk("gap_range", {255'h0, (gt >= 2 && gt <= 9)}, 256'h1);
                    if (gt < 16) seen[gt] = 1'b1;
                    wall_cols++;
                    if (p > SPACING) chk("wall_same", {240'h0, c15}, {240'h0, prev_wall});
                    prev_wall = c15;
                    if (first_wall_tick < 0) begin
                        first_wall_tick = tick_cnt;
                        first_wall = c15;
                    end
                end
                if (!bird_done && first_wall_tick > 0 && tick_cnt == first_wall_tick + 15 - BIRD_COL) begin
                    bird_done = 1'b1;
                    chk("bird_col", {240'h0, greenpix}, {240'h0, first_wall});
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        do begin
            cyc(1);
            n++;
        end while (!tick && n < 50);
        if (!tick) chk(tag, 256'h0, 256'h1);
    endtask

    logic [255:0] snap;
    int           n_int;
    int           distinct;

    initial begin
        #1;
        chk("rst_array", green_array, 256'h0);
        chk("rst_pix", {240'h0, greenpix}, 256'h0);
        chk("rst_tick", {255'h0, tick}, 256'h0);
        cyc(2);
        rst_n = 1'b1;
        enable = 1'b1;
        cyc(1);
        chk("first_tick_early", {255'h0, tick}, 256'h0);
        cyc(1);
        chk("first_tick", {255'h0, tick}, 256'h1);
        chk("first_col_blank", {240'h0, dut_col(green_array, 15)}, 256'h0);
        cyc(40);

        // Freeze with stop raised while the divider sits at its last count.
        wait_tick("freeze_wait");
        cyc(1);
        stop = 1'b1;
        snap = green_array;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("freeze_hold", green_array, snap);
            chk("freeze_tick", {255'h0, tick}, 256'h0);
        end
        stop = 1'b0;
        cyc(1);
        chk("unfreeze_tick", {255'h0, tick}, 256'h1);

        // Enable dropped for 10 cycles mid-period stretches the interval by 10.
        wait_tick("enable_wait");
        n_int = 1;
        cyc(1);
        enable = 1'b0;
        cyc(10);
        n_int += 10;
        enable = 1'b1;
        do begin
            cyc(1);
            n_int++;
        end while (!tick && n_int < 60);
        chk("enable_interval", 256'(n_int), 256'(TICK_DIV + 10));

        repeat (400) begin
            cyc(1);
            enable = ($urandom_range(0, 3) != 0);
            stop   = ($urandom_range(0, 4) == 0);
        end
        enable = 1'b1;
        stop = 1'b0;

        n_int = 0;
        while (wall_cols < 100 + PIPE_W && n_int < 3000) begin
            cyc(1);
            n_int++;
        end
        chk("fifty_walls", {255'h0, (wall_cols >= 100)}, 256'h1);
        distinct = 0;
        for (int i = 0; i < 16; i++) if (seen[i]) distinct++;
        chk("gap_distinct", {255'h0, (distinct >= 4)}, 256'h1);
        chk("bird_seen", {255'h0, bird_done}, 256'h1);

        // Reset mid-run with a populated playfield.
        chk("prereset_nonzero", {255'h0, (green_array != 256'h0)}, 256'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_array", green_array, 256'h0);
        chk("midrst_pix", {240'h0, greenpix}, 256'h0);
        chk("midrst_tick", {255'h0, tick}, 256'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk("rerun_tick_early", {255'h0, tick}, 256'h0);
        cyc(1);
        chk("rerun_tick", {255'h0, tick}, 256'h1);
        chk("rerun_blank", {240'h0, dut_col(green_array, 15)}, 256'h0);
        cyc(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
